// File: rtl/addr_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen_pkg
//  Description : Shared constants for the test-address generator: default
//                address width, address-mode encodings, default LFSR
//                feedback mask and seed, and FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package addr_gen_pkg;

  // Default address width used when the top is instantiated without AW
  localparam int ADDR_WIDTH = 8;

  // Address-mode encodings; 2'b11 is folded onto ADMD_LIN at latch time
  localparam logic [1:0] ADMD_LIN = 2'b00;
  localparam logic [1:0] ADMD_PR  = 2'b01;
  localparam logic [1:0] ADMD_CPL = 2'b10;

  // x^8+x^6+x^5+x^4+1, left-shifting Fibonacci form
  localparam logic [15:0] LFSR_TAPS_DEF = 16'h00B8;
  localparam logic [15:0] LFSR_SEED_DEF = 16'h0001;

  // Sweep FSM states
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

endpackage : addr_gen_pkg
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_step
//  Description : Combinational LFSR next-state logic. Produces both the
//                forward successor and the reverse predecessor of a state,
//                so a sweep can be walked in either direction.
//  Ports       : i_state  current LFSR state
//                o_fwd    forward successor
//                o_rev    predecessor (exact inverse of o_fwd)
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_step
  import addr_gen_pkg::*;
#(
  parameter int            AW        = ADDR_WIDTH,
  parameter logic [AW-1:0] LFSR_TAPS = AW'(LFSR_TAPS_DEF)
) (
  input  logic [AW-1:0] i_state,
  output logic [AW-1:0] o_fwd,
  output logic [AW-1:0] o_rev
);

  // Shift left, feedback parity enters at bit 0
  assign o_fwd = {i_state[AW-2:0], ^(i_state & LFSR_TAPS)};

  // Bit 0 of the state holds the last feedback bit. Since the top tap is
  // always set, the evicted MSB is recovered by removing the other taps'
  // contribution from that feedback bit.
  assign o_rev = {i_state[0] ^ (^(i_state[AW-1:1] & LFSR_TAPS[AW-2:0])),
                  i_state[AW-1:1]};

endmodule : lfsr_step
`default_nettype wire

// File: rtl/addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : addr_gen
//  Description : Memory-test address generator. On start, loads the first
//                address of a linear, pseudo-random (LFSR) or
//                address-complement sweep, then advances one address per
//                accepted step. Flags the final address and pulses done on
//                the step after it; the address never wraps.
//  Ports       : clk       clock, rising edge
//                rst_n     asynchronous active-low reset
//                admd_in   address mode (00 lin, 01 LFSR, 10 compl, 11 lin)
//                updwn_in  direction, 0 up / 1 down
//                start_in  begin a sweep (wins over step_in)
//                step_in   advance one address
//                tas_out   current test address
//                busy_out  sweep in progress
//                last_out  tas_out is the final address of the sweep
//                done_out  one-cycle completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module addr_gen
  import addr_gen_pkg::*;
#(
  parameter int            AW         = ADDR_WIDTH,
  parameter int            ADDR_FIRST = 0,
  parameter int            ADDR_LAST  = 2**AW - 1,
  parameter logic [AW-1:0] LFSR_TAPS  = AW'(LFSR_TAPS_DEF),
  parameter logic [AW-1:0] LFSR_SEED  = AW'(LFSR_SEED_DEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    admd_in,
  input  logic          updwn_in,
  input  logic          start_in,
  input  logic          step_in,
  output logic [AW-1:0] tas_out,
  output logic          busy_out,
  output logic          last_out,
  output logic          done_out
);

  localparam int CW = AW + 2;

  // Final counter value (span - 1) for each mode
  localparam logic [CW-1:0] c_LIN_M1 = CW'(ADDR_LAST - ADDR_FIRST);
  localparam logic [CW-1:0] c_PR_M1  = CW'((2**AW) - 2);
  localparam logic [CW-1:0] c_CPL_M1 = CW'(2 * (ADDR_LAST - ADDR_FIRST + 1) - 1);

  localparam logic [AW-1:0] c_FIRST   = AW'(ADDR_FIRST);
  localparam logic [AW-1:0] c_LAST    = AW'(ADDR_LAST);
  localparam logic [AW-1:0] c_ONE     = AW'(1);
  localparam logic [CW-1:0] c_CNT_ONE = CW'(1);

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [1:0]    r_mode;
  logic          r_dn;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_tas;
  logic          r_last;
  logic          r_done;
  logic          r_phase;     // complement mode: 0 = at base, 1 = at ~base

  logic [1:0]    w_mode_in;
  logic [AW-1:0] w_tas_load;
  logic [AW-1:0] w_tas_step;
  logic [AW-1:0] w_fwd;
  logic [AW-1:0] w_rev;
  logic [AW-1:0] w_ntas;
  logic [CW-1:0] w_nm1_in;
  logic [CW-1:0] w_nm1;
  logic [CW-1:0] w_cnt_inc;
  logic          w_load;
  logic          w_adv;
  logic          w_fin;

  function automatic logic [CW-1:0] span_m1(input logic [1:0] mode);
    case (mode)
      ADMD_PR:  span_m1 = c_PR_M1;
      ADMD_CPL: span_m1 = c_CPL_M1;
      default:  span_m1 = c_LIN_M1;
    endcase
  endfunction

  lfsr_step #(
    .AW        (AW),
    .LFSR_TAPS (LFSR_TAPS)
  ) u_lfsr_step (
    .i_state (r_tas),
    .o_fwd   (w_fwd),
    .o_rev   (w_rev)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_in) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!start_in && step_in && r_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load   = start_in;
    w_adv    = (r_state == S_RUN) && step_in && !start_in && !r_last;
    w_fin    = (r_state == S_RUN) && step_in && !start_in &&  r_last;
    busy_out = (r_state == S_RUN);
  end

  // ---------------------------------------------------------- datapath
  assign w_mode_in = (admd_in == 2'b11) ? ADMD_LIN : admd_in;
  assign w_nm1_in  = span_m1(w_mode_in);
  assign w_nm1     = span_m1(r_mode);
  assign w_cnt_inc = r_cnt + c_CNT_ONE;
  assign w_ntas    = ~r_tas;

  always_comb begin
    w_tas_load = updwn_in ? c_LAST : c_FIRST;
    if (w_mode_in == ADMD_PR) w_tas_load = LFSR_SEED;
  end

  always_comb begin
    w_tas_step = r_dn ? (r_tas - c_ONE) : (r_tas + c_ONE);
    case (r_mode)
      ADMD_PR:  w_tas_step = r_dn ? w_rev : w_fwd;
      ADMD_CPL: begin
        // From base emit ~base; from ~base recover base and move it by one
        if (!r_phase) w_tas_step = w_ntas;
        else          w_tas_step = r_dn ? (w_ntas - c_ONE) : (w_ntas + c_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= ADMD_LIN;
      r_dn    <= 1'b0;
      r_cnt   <= '0;
      r_tas   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_mode  <= w_mode_in;
        r_dn    <= updwn_in;
        r_cnt   <= '0;
        r_tas   <= w_tas_load;
        r_phase <= 1'b0;
        r_last  <= (w_nm1_in == '0);
      end else if (w_adv) begin
        r_tas   <= w_tas_step;
        r_cnt   <= w_cnt_inc;
        r_phase <= ~r_phase;
        r_last  <= (w_cnt_inc == w_nm1);
      end else if (w_fin) begin
        // Address holds on the final step; only the flags change
        r_done <= 1'b1;
        r_last <= 1'b0;
      end
    end
  end

  assign tas_out  = r_tas;
  assign last_out = r_last;
  assign done_out = r_done;

endmodule : addr_gen
`default_nettype wire
